// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver: 2-FF synchroniser, start-bit validation,
// 2-of-3 majority vote at mid-bit, framing check.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled #(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] dat,
   output logic       dat_en,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned TCK_W  = $clog2(OVERSAMPLE);
   localparam int unsigned WIN_LO = OVERSAMPLE / 2 - 1;
   localparam int unsigned WIN_HI = OVERSAMPLE / 2 + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic               rx_meta, rs, rs_d;
   logic [DIV_W-1:0]   div_cnt;
   logic [TCK_W-1:0]   tick_cnt;
   logic [1:0]         ones;
   logic [2:0]         bit_idx;
   logic [7:0]         shreg;
   logic               tick, in_win, win_end, vote, start_fall;
   logic               dat_en_d, frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic               par_err_q;
`endif

   assign tick       = (div_cnt == DIV_W'(DIV - 1));
   assign in_win     = tick && (tick_cnt >= TCK_W'(WIN_LO)) && (tick_cnt <= TCK_W'(WIN_HI));
   assign win_end    = tick && (tick_cnt == TCK_W'(WIN_HI));
   // ones holds the first two samples; the third is the live rs value
   assign vote       = ones[1] | (ones[0] & rs);
   assign start_fall = rs_d & ~rs;

   // Synchronise the asynchronous rx pin and keep one extra stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rs      <= 1'b1;
         rs_d    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rs      <= rx_meta;
         rs_d    <= rs;
      end
   end

   // Tick divider, per-bit tick counter and vote accumulator; held at zero while idle
   // so the bit phase starts aligned to the detected falling edge
   always_ff @(posedge clk) begin
      if (rst || state_q == S_IDLE || state_q == S_BREAK) begin
         div_cnt  <= '0;
         tick_cnt <= '0;
         ones     <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         if (tick)
            tick_cnt <= (tick_cnt == TCK_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt + TCK_W'(1);
         if (win_end)
            ones <= '0;
         else if (in_win)
            ones <= ones + {1'b0, rs};
      end
   end

   // Shift register, bit index and held parity result
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         if (state_q == S_START && win_end)
            bit_idx <= '0;
         if (state_q == S_DATA && win_end) begin
            shreg   <= {vote, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
`ifdef UART_RX_PARITY_EN
         if (state_q == S_PARITY && win_end)
            par_err_q <= vote ^ (^shreg);
`endif
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and strobe decode
   always_comb begin
      state_d     = state_q;
      dat_en_d    = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         S_IDLE:  if (start_fall) state_d = S_START;
         S_START: if (win_end) state_d = vote ? S_IDLE : S_DATA;
         S_DATA:
            if (win_end && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (win_end) state_d = S_STOP;
`endif
         S_STOP:
            if (win_end) begin
               if (vote) begin
                  state_d  = S_IDLE;
                  dat_en_d = 1'b1;
               end else begin
                  state_d     = S_BREAK;
                  frame_err_d = 1'b1;
               end
            end
         S_BREAK: if (rs) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         dat       <= '0;
         dat_en    <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         dat_en    <= dat_en_d;
         frame_err <= frame_err_d;
         busy      <= (state_d != S_IDLE) && (state_d != S_BREAK);
         if (dat_en_d)
            dat <= shreg;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity error strobe accompanies the data strobe
   always_ff @(posedge clk) begin
      if (rst) parity_err <= 1'b0;
      else     parity_err <= dat_en_d & par_err_q;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled; DIV=6 gives 96 clk per bit.
module tb_uart_rx_oversampled;

   localparam int unsigned CLK_FREQ = 96000000;
   localparam int unsigned BAUD     = 1000000;
   localparam int unsigned OS       = 16;
   localparam int          BIT      = 96;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int NB = PAR_EN ? 10 : 9;

   logic       clk = 1'b0;
   logic       rst, rx;
   logic [7:0] dat;
   logic       dat_en, frame_err, parity_err, busy;

   uart_rx_oversampled #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
      .clk(clk), .rst(rst), .rx(rx), .dat(dat), .dat_en(dat_en),
      .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         ferr;
      logic [7:0] dat;
      logic       perr;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         en_cyc = 0;
   logic [7:0] last_good = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pop an expectation on every strobe
   always @(negedge clk) begin
      if (!rst && (dat_en === 1'b1 || frame_err === 1'b1 || parity_err === 1'b1)) begin
         check("strobe_exclusive", 32'(dat_en & frame_err), 32'd0);
         check("parity_alone", 32'(parity_err & ~dat_en), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'({dat_en, frame_err}), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("strobe_kind", 32'(frame_err), 32'(mon_e.ferr));
            check("dat", 32'(dat), 32'(mon_e.dat));
            check("parity_err", 32'(parity_err), 32'(mon_e.perr));
            if (dat_en) en_cyc = cyc;
         end
      end
   end

   function automatic int blen(input int i, input bit jit);
      if (!jit) return BIT;
      return (i % 2 == 1) ? BIT + 3 : BIT - 3;
   endfunction

   task automatic drive_bit(input logic v, input int len);
      rx = v;
      repeat (len) @(negedge clk);
   endtask

   // Send one frame and push its expected outcome
   task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic bad_par, input bit jit);
      exp_t e;
      if (stop_v) begin
         e.ferr = 1'b0; e.dat = d; e.perr = bad_par & PAR_EN;
         last_good = d;
      end else begin
         e.ferr = 1'b1; e.dat = last_good; e.perr = 1'b0;
      end
      exp_q.push_back(e);
      drive_bit(1'b0, blen(0, jit));
      for (int b = 0; b < 8; b++) drive_bit(d[b], blen(b + 1, jit));
      if (PAR_EN) drive_bit((^d) ^ bad_par, blen(9, jit));
      drive_bit(stop_v, blen(10, jit));
   endtask

   initial begin
      int t0;
      logic [7:0] b77;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_dat", 32'(dat), 32'h0);
      check("rst_dat_en", 32'(dat_en), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_parity_err", 32'(parity_err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (2 * BIT) @(negedge clk);

      // 1: single 0x55, latency and busy
      t0 = cyc;
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      check("t1_latency_ok", 32'((en_cyc - t0 >= NB * BIT) && (en_cyc - t0 <= (NB + 1) * BIT)), 32'd1);
      check("t1_busy_after", 32'(busy), 32'h0);
      repeat (BIT) @(negedge clk);

      // 2: short low glitch is a false start
      drive_bit(1'b0, 11);
      check("t2_busy_during", 32'(busy), 32'h1);
      drive_bit(1'b1, BIT);
      check("t2_busy_after", 32'(busy), 32'h0);
      repeat (BIT) @(negedge clk);

      // 3: framing error then line held low, then a clean frame
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b0, 250);
      check("t3_busy_break", 32'(busy), 32'h0);
      drive_bit(1'b1, 2 * BIT);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      repeat (BIT) @(negedge clk);

      // 4: back-to-back, then with jittered bit edges
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      send_frame(8'h80, 1'b1, 1'b0, 1'b0);
      repeat (BIT) @(negedge clk);
      send_frame(8'h00, 1'b1, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
      send_frame(8'h80, 1'b1, 1'b0, 1'b1);
      repeat (BIT) @(negedge clk);

      // 5: reset during data bit 4 of 0x77; the transmitter abandons the frame
      b77 = 8'h77;
      drive_bit(1'b0, BIT);
      for (int b = 0; b < 4; b++) drive_bit(b77[b], BIT);
      drive_bit(b77[4], BIT / 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_good = 8'h00;
      check("t5_dat", 32'(dat), 32'h0);
      check("t5_dat_en", 32'(dat_en), 32'h0);
      check("t5_frame_err", 32'(frame_err), 32'h0);
      check("t5_parity_err", 32'(parity_err), 32'h0);
      check("t5_busy", 32'(busy), 32'h0);
      drive_bit(1'b1, 3 * BIT);
      send_frame(8'h12, 1'b1, 1'b0, 1'b0);
      repeat (BIT) @(negedge clk);

      // 6: good and corrupted parity bit (plain frames when parity is off)
      send_frame(8'h03, 1'b1, 1'b0, 1'b0);
      send_frame(8'h03, 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 4 * BIT && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      repeat (BIT) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
